// File: rtl/uart_tx_parity.sv
// uart_tx_parity: UART transmitter, 8 data bits, LSB first, one stop bit.
// Configuration macro UART_TX_PARITY_EN: when defined, an even parity bit
// is sent between the data bits and the stop bit (8E1, 11-bit frame).
// When undefined the frame is 8N1 (10 bits); the parity register is still
// loaded on acceptance but never driven onto the line.
// All outputs are registered; each frame bit lasts CLK_CY_PER_BIT cycles.
module uart_tx_parity #(
   parameter int CLK_CY_PER_BIT = 87
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_Tx_Dv,
   input  logic [7:0] i_Tx_Byte,
   output logic       o_Tx_Active,
   output logic       o_Tx_Serial,
   output logic       o_Tx_Done
);

   localparam int CNT_W = (CLK_CY_PER_BIT > 1) ? $clog2(CLK_CY_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_CY_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      PARITY  = 3'd3,
      STOP    = 3'd4,
      CLEANUP = 3'd5
   } state_t;

   // Even parity bit: makes the total count of ones (data + parity) even.
   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

   state_t           r_state,      w_state_nxt;
   logic [CNT_W-1:0] r_clk_cnt,    w_clk_cnt_nxt;
   logic [2:0]       r_bit_idx,    w_bit_idx_nxt;
   logic [7:0]       r_tx_data,    w_tx_data_nxt;
   logic             r_parity_out, w_parity_out_nxt;
   logic             r_tx_serial,  w_tx_serial_nxt;
   logic             r_tx_active,  w_tx_active_nxt;
   logic             r_tx_done,    w_tx_done_nxt;

   logic [2:0]       w_bit_idx_inc;
   logic             w_bit_end;

   assign w_bit_idx_inc = r_bit_idx + 3'd1;
   assign w_bit_end     = (r_clk_cnt == CNT_LAST);

   // State, counters, latched byte and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_clk_cnt    <= '0;
         r_bit_idx    <= '0;
         r_tx_data    <= '0;
         r_parity_out <= 1'b0;
         r_tx_serial  <= 1'b1;
         r_tx_active  <= 1'b0;
         r_tx_done    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_clk_cnt    <= w_clk_cnt_nxt;
         r_bit_idx    <= w_bit_idx_nxt;
         r_tx_data    <= w_tx_data_nxt;
         r_parity_out <= w_parity_out_nxt;
         r_tx_serial  <= w_tx_serial_nxt;
         r_tx_active  <= w_tx_active_nxt;
         r_tx_done    <= w_tx_done_nxt;
      end
   end

   // Next-state and next-output logic; the line level for the next bit is
   // computed at the bit boundary so the output register changes in step
   // with the state.
   always_comb begin
      w_state_nxt      = r_state;
      w_clk_cnt_nxt    = r_clk_cnt;
      w_bit_idx_nxt    = r_bit_idx;
      w_tx_data_nxt    = r_tx_data;
      w_parity_out_nxt = r_parity_out;
      w_tx_serial_nxt  = r_tx_serial;
      w_tx_active_nxt  = r_tx_active;
      w_tx_done_nxt    = 1'b0;

      case (r_state)
         IDLE: begin
            w_tx_serial_nxt = 1'b1;
            w_tx_active_nxt = 1'b0;
            w_clk_cnt_nxt   = '0;
            w_bit_idx_nxt   = '0;
            if (i_Tx_Dv) begin
               w_tx_data_nxt    = i_Tx_Byte;
               w_parity_out_nxt = even_parity(i_Tx_Byte);
               w_tx_serial_nxt  = 1'b0;
               w_tx_active_nxt  = 1'b1;
               w_state_nxt      = START;
            end
         end

         START: begin
            w_tx_serial_nxt = 1'b0;
            if (w_bit_end) begin
               w_clk_cnt_nxt   = '0;
               w_bit_idx_nxt   = '0;
               w_tx_serial_nxt = r_tx_data[0];
               w_state_nxt     = DATA;
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
            end
         end

         DATA: begin
            w_tx_serial_nxt = r_tx_data[r_bit_idx];
            if (w_bit_end) begin
               w_clk_cnt_nxt = '0;
               if (r_bit_idx == 3'd7) begin
                  w_bit_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
                  w_tx_serial_nxt = r_parity_out;
                  w_state_nxt     = PARITY;
`else
                  w_tx_serial_nxt = 1'b1;
                  w_state_nxt     = STOP;
`endif
               end else begin
                  w_bit_idx_nxt   = w_bit_idx_inc;
                  w_tx_serial_nxt = r_tx_data[w_bit_idx_inc];
               end
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
            end
         end

         PARITY: begin
            w_tx_serial_nxt = r_parity_out;
            if (w_bit_end) begin
               w_clk_cnt_nxt   = '0;
               w_tx_serial_nxt = 1'b1;
               w_state_nxt     = STOP;
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
            end
         end

         STOP: begin
            w_tx_serial_nxt = 1'b1;
            if (w_bit_end) begin
               w_clk_cnt_nxt   = '0;
               w_tx_active_nxt = 1'b0;
               w_tx_done_nxt   = 1'b1;
               w_state_nxt     = CLEANUP;
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
            end
         end

         CLEANUP: begin
            w_tx_serial_nxt = 1'b1;
            w_tx_active_nxt = 1'b0;
            w_clk_cnt_nxt   = '0;
            w_state_nxt     = IDLE;
         end

         default: begin
            w_tx_serial_nxt = 1'b1;
            w_tx_active_nxt = 1'b0;
            w_clk_cnt_nxt   = '0;
            w_bit_idx_nxt   = '0;
            w_state_nxt     = IDLE;
         end
      endcase
   end

   assign o_Tx_Serial = r_tx_serial;
   assign o_Tx_Active = r_tx_active;
   assign o_Tx_Done   = r_tx_done;

endmodule

// File: tb/tb_uart_tx_parity.sv
// Bench for uart_tx_parity: table of directed bytes with hand-computed
// parity, plus hand-written sequences for back-to-back frames and reset.
module tb_uart_tx_parity;

   localparam int N = 87;
`ifdef UART_TX_PARITY_EN
   localparam int F = 11;
`else
   localparam int F = 10;
`endif

   logic       i_clk;
   logic       i_rst_n;
   logic       i_Tx_Dv;
   logic [7:0] i_Tx_Byte;
   logic       o_Tx_Active;
   logic       o_Tx_Serial;
   logic       o_Tx_Done;

   uart_tx_parity #(.CLK_CY_PER_BIT(N)) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_Tx_Dv    (i_Tx_Dv),
      .i_Tx_Byte  (i_Tx_Byte),
      .o_Tx_Active(o_Tx_Active),
      .o_Tx_Serial(o_Tx_Serial),
      .o_Tx_Done  (o_Tx_Done)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_vec  = 0;
   int n_miss = 0;
   int done_cnt = 0;

   // Count completion pulses away from the active edge.
   always @(negedge i_clk) if (o_Tx_Done === 1'b1) done_cnt++;

   typedef struct {
      logic [7:0] data;
      logic       par;
      int         inject;
   } vec_t;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Request one frame from IDLE and check every cycle of it. Called with
   // the time just after an edge. inject >= 0 pulses a 0x55 request at that
   // frame cycle. Returns just after the edge following CLEANUP.
   task automatic send_frame(input logic [7:0] b, input logic par, input int inject);
      logic exp_bits[0:10];
      int   bad;
      exp_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
      exp_bits[9]  = par;
      exp_bits[10] = 1'b1;
`ifndef UART_TX_PARITY_EN
      exp_bits[9]  = 1'b1;
`endif
      i_Tx_Byte = b;
      i_Tx_Dv   = 1'b1;
      @(posedge i_clk); #1;
      i_Tx_Dv   = 1'b0;
      i_Tx_Byte = ~b;
      check($sformatf("parity_reg %02h", b), 32'(dut.r_parity_out), 32'(par));
      for (int i = 0; i < F; i++) begin
         bad = 0;
         for (int c = 0; c < N; c++) begin
            if (o_Tx_Serial !== exp_bits[i] || o_Tx_Active !== 1'b1 || o_Tx_Done !== 1'b0)
               bad++;
            if (i*N + c == inject) begin
               i_Tx_Dv   = 1'b1;
               i_Tx_Byte = 8'h55;
            end else if (i*N + c == inject + 1) begin
               i_Tx_Dv = 1'b0;
            end
            @(posedge i_clk); #1;
         end
         check($sformatf("byte %02h bit %0d wrong cycles", b, i), 32'(bad), 32'd0);
      end
      check($sformatf("byte %02h cleanup {done,act,ser}", b),
            32'({o_Tx_Done, o_Tx_Active, o_Tx_Serial}), 32'(3'b101));
      @(posedge i_clk); #1;
      check($sformatf("byte %02h idle {done,act,ser}", b),
            32'({o_Tx_Done, o_Tx_Active, o_Tx_Serial}), 32'(3'b001));
   endtask

   vec_t vecs[7];
   int   d0;
   int   bad_idle;

   initial begin
      vecs[0] = '{8'hAA, 1'b0, -1};
      vecs[1] = '{8'h01, 1'b1, -1};
      vecs[2] = '{8'h00, 1'b0, -1};
      vecs[3] = '{8'hAA, 1'b0, 4*N + 10};
      vecs[4] = '{8'hFF, 1'b0, -1};
      vecs[5] = '{8'h80, 1'b1, -1};
      vecs[6] = '{8'h6B, 1'b1, -1};

      // Reset state
      i_rst_n   = 1'b0;
      i_Tx_Dv   = 1'b0;
      i_Tx_Byte = 8'h00;
      repeat (3) @(posedge i_clk);
      #1;
      check("reset {done,act,ser}", 32'({o_Tx_Done, o_Tx_Active, o_Tx_Serial}), 32'(3'b001));
      check("reset parity_reg", 32'(dut.r_parity_out), 32'd0);
      check("reset latched byte", 32'(dut.r_tx_data), 32'd0);
      i_rst_n = 1'b1;

      // Table-driven frames, each followed by a quiet-line check
      for (int v = 0; v < 7; v++) begin
         send_frame(vecs[v].data, vecs[v].par, vecs[v].inject);
         bad_idle = 0;
         for (int c = 0; c < 2*N; c++) begin
            if (o_Tx_Serial !== 1'b1 || o_Tx_Active !== 1'b0 || o_Tx_Done !== 1'b0)
               bad_idle++;
            @(posedge i_clk); #1;
         end
         check($sformatf("vector %0d quiet line cycles", v), 32'(bad_idle), 32'd0);
      end

      // Back-to-back frames: second request in the IDLE cycle after CLEANUP
      d0 = done_cnt;
      send_frame(8'h3C, 1'b0, -1);
      send_frame(8'hC3, 1'b0, -1);
      repeat (4) @(posedge i_clk);
      #1;
      check("back-to-back done pulses", 32'(done_cnt - d0), 32'd2);

      // Reset in the middle of the DATA state
      i_Tx_Byte = 8'hAA;
      i_Tx_Dv   = 1'b1;
      @(posedge i_clk); #1;
      i_Tx_Dv = 1'b0;
      repeat (3*N) @(posedge i_clk);
      #3;
      d0 = done_cnt;
      check("pre-reset active", 32'(o_Tx_Active), 32'd1);
      i_rst_n = 1'b0;
      #1;
      check("async reset {done,act,ser}", 32'({o_Tx_Done, o_Tx_Active, o_Tx_Serial}), 32'(3'b001));
      repeat (3) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      repeat (2*N) @(posedge i_clk);
      #1;
      check("aborted frame done pulses", 32'(done_cnt - d0), 32'd0);
      check("post-reset {done,act,ser}", 32'({o_Tx_Done, o_Tx_Active, o_Tx_Serial}), 32'(3'b001));

      // First request after reset release is accepted on the next edge
      i_rst_n = 1'b0;
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      send_frame(8'h01, 1'b1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/uart_tx_parity.md
UART_TX_PARITY -- requirements
Module: uart_tx_parity

Interface
REQ-001 Parameter CLK_CY_PER_BIT, default 87, is the number of i_clk cycles per serial bit (10 MHz / 115200 baud); legal range 2..65535.
REQ-002 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 i_Tx_Dv  input  1  data-valid strobe; requests transmission of i_Tx_Byte.
REQ-005 i_Tx_Byte  input  8  byte to transmit, sampled when a request is accepted.
REQ-006 o_Tx_Active  output  1  high while a frame is on the line.
REQ-007 o_Tx_Serial  output  1  serial line; idles high.
REQ-008 o_Tx_Done  output  1  one-cycle pulse marking frame completion.

Function
REQ-009 Frame format, bit by bit: start bit 0; data bits 0..7, LSB first; even parity bit; stop bit 1.
REQ-010 Each frame bit shall be held on o_Tx_Serial for exactly CLK_CY_PER_BIT cycles.
REQ-011 States: IDLE, START, DATA, PARITY, STOP, CLEANUP.
REQ-012 IDLE: o_Tx_Serial=1 and o_Tx_Active=0.
REQ-013 Acceptance: i_Tx_Dv=1 at a rising edge in IDLE shall latch i_Tx_Byte and enter START.
REQ-014 Acceptance shall latch internal register r_parity_out = XOR reduction of i_Tx_Byte.
REQ-015 o_Tx_Serial shall go low and o_Tx_Active high on the cycle after acceptance (latency 1 cycle).
REQ-016 START -> DATA after CLK_CY_PER_BIT cycles.
REQ-017 DATA uses a 3-bit bit index; after bit 7 completes -> PARITY.
REQ-018 PARITY drives r_parity_out for CLK_CY_PER_BIT cycles, then -> STOP.
REQ-019 STOP drives 1 for CLK_CY_PER_BIT cycles, then -> CLEANUP.
REQ-020 CLEANUP lasts one cycle: o_Tx_Done=1, o_Tx_Active=0, o_Tx_Serial=1, then -> IDLE.
REQ-021 o_Tx_Done shall be 0 in every state except CLEANUP.
REQ-022 i_Tx_Dv shall be ignored in all states except IDLE; no queuing.
REQ-023 Changes to i_Tx_Byte after acceptance shall not affect the frame in progress.
REQ-024 A new request asserted in the IDLE cycle following CLEANUP shall be accepted (back-to-back frames).
REQ-025 Bit-cycle counter width is clog2(CLK_CY_PER_BIT); it clears at every bit boundary.
REQ-026 All outputs shall be registered.

Reset
REQ-027 Asserting i_rst_n=0 shall immediately force: state IDLE, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, counters 0, r_parity_out 0, latched byte 0.
REQ-028 Reset mid-frame shall abort the frame with no o_Tx_Done pulse.
REQ-029 After deassertion, the first request is accepted on the next rising edge.

Configuration
REQ-030 Macro UART_TX_PARITY_EN defined: the PARITY state and parity bit are included (11-bit frame, 8E1).
REQ-031 Macro UART_TX_PARITY_EN undefined: DATA -> STOP directly (10-bit frame, 8N1); r_parity_out is still computed but never transmitted.

Verification
REQ-032 Send 0xAA with UART_TX_PARITY_EN, CLK_CY_PER_BIT=87 -> serial 0,0,1,0,1,0,1,0,1,0(parity),1, each bit 87 cycles; o_Tx_Done pulses 957 cycles after the first low; r_parity_out=0.
REQ-033 Send 0x01 -> parity bit 1, r_parity_out=1; 0x00 -> parity bit 0.
REQ-034 Pulse i_Tx_Dv with 0x55 mid-frame of 0xAA -> the 0xAA frame is unaltered and no second frame is sent.
REQ-035 Send 0x3C then, one cycle after o_Tx_Done, 0xC3 -> two contiguous correct frames; o_Tx_Done pulses exactly twice.
REQ-036 Assert i_rst_n low during the DATA state -> o_Tx_Serial=1 and o_Tx_Active=0 immediately; no o_Tx_Done pulse.
REQ-037 Without UART_TX_PARITY_EN, send 0xAA -> 10-bit frame; o_Tx_Done pulses 870 cycles after the start bit.
